lc3b_mem_bridge: RTL and testbench
==================================

Name: lc3b_mem_bridge

Overview:
Sits directly downstream of the LC-3b CPU memory port. It converts CPU requests (mem_read/mem_write, byte address, 2-bit byte mask) into accesses on a word-only physical memory bus (pmem_*) with variable latency. Full-word writes pass straight through. Partial-byte writes are performed as read-modify-write. A watchdog aborts physical accesses that never complete, so the CPU cannot hang.

Parameters:
TIMEOUT, 64, max cycles to wait for pmem_resp per physical access; 0 disables the watchdog.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; synchronous, active-low
mem_read  input  1  CPU read request; held until mem_resp
mem_write  input  1  CPU write request; held until mem_resp
mem_byte_enable  input  2  write byte mask (lc3b_mem_wmask); bit0 = low byte, bit1 = high byte
mem_address  input  16  CPU byte address (lc3b_word)
mem_wdata  input  16  CPU write data
mem_resp  output  1  one-cycle completion pulse to the CPU
mem_rdata  output  16  read data, valid while mem_resp = 1
mem_err  output  1  pulses with mem_resp when the access timed out
pmem_read  output  1  physical read strobe
pmem_write  output  1  physical write strobe
pmem_address  output  16  physical word address; bit0 always 0
pmem_wdata  output  16  physical write data
pmem_resp  input  1  physical access complete, one-cycle pulse
pmem_rdata  input  16  physical read data, valid with pmem_resp

Behaviour:
- Reset (rst_n = 0 at a clock edge): state goes to IDLE. All outputs are 0, including mem_rdata = 16'h0000. Latches and the watchdog counter are cleared.
- Reset mid-operation: the in-flight physical access is abandoned and no mem_resp is issued. A late pmem_resp arriving in IDLE is ignored.
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE: at the first edge where a request is present, latch address (bit0 cleared for pmem), wdata and mask. Then go to:
  - READ if mem_read = 1. Read wins if mem_read and mem_write are both 1.
  - WRITE if mem_write = 1 and mask = 2'b11.
  - RMW_READ if mem_write = 1 and mask = 2'b01 or 2'b10.
  - RESP directly if mem_write = 1 and mask = 2'b00. No physical access occurs.
- Changes to CPU inputs after the request is accepted are ignored until the next IDLE.
- pmem_read = 1 exactly in READ and RMW_READ. pmem_write = 1 exactly in WRITE. These strobes are decoded from the state register only.
- pmem_address and pmem_wdata come from the latches and are stable for the whole access.
- READ: on pmem_resp, capture pmem_rdata into the mem_rdata register and go to RESP.
- RMW_READ: on pmem_resp, build the merged word:
  - low byte = mask[0] ? wdata[7:0] : pmem_rdata[7:0]
  - high byte = mask[1] ? wdata[15:8] : pmem_rdata[15:8]
  - load the merged word into pmem_wdata, then go to WRITE.
- WRITE: on pmem_resp, go to RESP.
- pmem_resp in IDLE or RESP is ignored.
- RESP: mem_resp = 1 for exactly one cycle, then IDLE.
  - mem_rdata holds the read word for read requests. It is 16'h0000 for writes and resets to 0 in IDLE.
  - The requester must deassert, or present a new request, in the cycle after mem_resp. IDLE accepts a new request immediately.
- Latency: request sampled at edge k → pmem strobe high in cycle k+1.
  - A pmem_resp at the edge ending cycle k+n gives mem_resp in cycle k+n+1.
  - Best case: read or full write = 2 cycles to mem_resp; partial write = 3 cycles.
- Watchdog:
  - Counter reloads at entry to READ, RMW_READ and WRITE.
  - It increments each cycle in those states without pmem_resp.
  - If it reaches TIMEOUT before pmem_resp: go to RESP with mem_err = 1 and mem_rdata = 16'h0000. In RMW_READ, no write is performed.
  - pmem_resp in the same cycle as the expiry wins; no error is raised.
  - The counter is wide enough for TIMEOUT with no wrap.
  - TIMEOUT = 0 means wait forever.
- Address wrap: 16'hFFFF maps to pmem_address 16'hFFFE. There is no overflow handling.

Test Plan:
1. Read, 3-cycle pmem latency, address 16'h0041 → pmem_address = 16'h0040, pmem_read high for 3 cycles; mem_resp one cycle later with mem_rdata = 16'hBEEF, mem_err = 0.
2. Write, mask 2'b11, wdata 16'h1234 to 16'h0100 → single pmem_write with pmem_wdata = 16'h1234; mem_resp 1 cycle after pmem_resp; pmem_read never asserted.
3. Write, mask 2'b01, wdata 16'hAA55, memory word 16'hC3C3 → pmem_read, then pmem_write with 16'hC355. Repeat with mask 2'b10 → pmem_write with 16'hAAC3.
4. Write, mask 2'b00 → no pmem strobes; mem_resp in cycle k+1. Separately, mem_read and mem_write both high → read performed, no write.
5. TIMEOUT = 8, pmem_resp held low → pmem_read high for 8 cycles; mem_resp with mem_err = 1 and mem_rdata = 0; a late pmem_resp afterward is ignored. Repeat with pmem_resp in the expiry cycle → mem_err = 0.
6. rst_n low for one cycle during RMW_READ → next cycle all outputs 0, no pmem_write, no mem_resp; a subsequent read completes normally.

Source files
------------

// File: rtl/lc3b_mem_bridge_if.sv
// CPU-side and physical-memory-side signals of the LC-3b memory bridge.
// The bridge connects through "slave"; the CPU/memory environment connects through "master".
interface lc3b_mem_bridge_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
  logic        mem_err;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic        pmem_resp;
  logic [15:0] pmem_rdata;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  pmem_resp, pmem_rdata,
    output mem_resp, mem_rdata, mem_err,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output pmem_resp, pmem_rdata,
    input  mem_resp, mem_rdata, mem_err,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/lc3b_mem_bridge.sv
// Byte-masked CPU requests onto a word-only physical bus; partial writes use read-modify-write.
// A watchdog bounds every physical access and reports expiry through mem_err.
module lc3b_mem_bridge #(
  parameter int unsigned TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  lc3b_mem_bridge_if.slave bus
);
  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    mask_q, mask_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired;
  logic [15:0]   merged;

  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);
  assign merged  = {mask_q[1] ? wdata_q[15:8] : bus.pmem_rdata[15:8],
                    mask_q[0] ? wdata_q[7:0]  : bus.pmem_rdata[7:0]};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        rdata_d = 16'h0000;
        err_d   = 1'b0;
        cnt_d   = '0;
        if (bus.mem_read || bus.mem_write) begin
          addr_d  = {bus.mem_address[15:1], 1'b0};
          wdata_d = bus.mem_wdata;
          mask_d  = bus.mem_byte_enable;
          if (bus.mem_read)                      state_d = READ;
          else if (bus.mem_byte_enable == 2'b11) state_d = WRITE;
          else if (bus.mem_byte_enable == 2'b00) state_d = RESP;
          else                                   state_d = RMW_READ;
        end
      end
      READ, RMW_READ, WRITE: begin
        // pmem_resp takes priority over a watchdog expiry in the same cycle
        if (bus.pmem_resp) begin
          if (state_q == READ) begin
            rdata_d = bus.pmem_rdata;
            state_d = RESP;
          end else if (state_q == RMW_READ) begin
            wdata_d = merged;
            cnt_d   = '0;
            state_d = WRITE;
          end else begin
            state_d = RESP;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          rdata_d = 16'h0000;
          state_d = RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        rdata_d = 16'h0000;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      mask_q  <= 2'b00;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pmem_read    = (state_q == READ) || (state_q == RMW_READ);
  assign bus.pmem_write   = (state_q == WRITE);
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.mem_resp     = (state_q == RESP);
  assign bus.mem_rdata    = rdata_q;
  assign bus.mem_err      = err_q;
endmodule

// File: tb/tb_lc3b_mem_bridge.sv
// Directed bench for lc3b_mem_bridge (TIMEOUT = 8) with a CPU response scoreboard
// and a physical-write scoreboard, both checked by monitors independent of stimulus.
module tb_lc3b_mem_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lc3b_mem_bridge_if bus();

  lc3b_mem_bridge #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] wq[$];
  int          errors = 0;
  int          checks = 0;
  int          resp_lat = 0;
  logic [15:0] mem_word = 16'h0000;
  logic        inject_late = 1'b0;
  int          cyc = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          resp_cnt = 0;
  logic [15:0] last_addr = 16'h0000;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Physical memory model: answers after resp_lat strobe cycles (0 = never).
  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      if (inject_late) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'hDEAD;
        inject_late    = 1'b0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        cyc++;
        last_addr = bus.pmem_address;
        if (bus.pmem_read) rd_cyc++;
        else               wr_cyc++;
        if (resp_lat != 0 && cyc == resp_lat) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_word;
          cyc = 0;
          if (bus.pmem_write) begin
            if (wq.size() == 0) check("unexpected_pmem_write", 64'(bus.pmem_wdata), 64'hFFFF_FFFF);
            else                check("pmem_wdata", 64'(bus.pmem_wdata), 64'(wq.pop_front()));
          end
        end
      end else begin
        cyc = 0;
      end
    end
  end

  // CPU response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_resp) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_mem_resp", 64'(bus.mem_resp), 64'd0);
        end else begin
          e = sb.pop_front();
          check("mem_rdata", 64'(bus.mem_rdata), 64'(e.rdata));
          check("mem_err", 64'(bus.mem_err), 64'(e.err));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b00;
    bus.mem_address     = 16'h0000;
    bus.mem_wdata       = 16'h0000;
  endtask

  task automatic check_outputs_zero(input string nm);
    check(nm, {bus.mem_resp, bus.mem_rdata, bus.mem_err, bus.pmem_read, bus.pmem_write,
               bus.pmem_address, bus.pmem_wdata}, 64'd0);
  endtask

  task automatic req(input string nm, input logic rd, input logic wr, input logic [1:0] m,
                     input logic [15:0] a, input logic [15:0] wd, input int lat,
                     input logic [15:0] word, input logic [15:0] exp_rd, input logic exp_err,
                     input logic has_wr, input logic [15:0] exp_w, input int exp_n,
                     input int exp_rc, input int exp_wc, input logic [15:0] exp_addr);
    int   n;
    logic got;
    exp_t e;
    resp_lat = lat;
    mem_word = word;
    e.rdata  = exp_rd;
    e.err    = exp_err;
    sb.push_back(e);
    if (has_wr) wq.push_back(exp_w);
    rd_cyc    = 0;
    wr_cyc    = 0;
    last_addr = 16'h0000;
    @(posedge clk);
    #1;
    bus.mem_read        = rd;
    bus.mem_write       = wr;
    bus.mem_byte_enable = m;
    bus.mem_address     = a;
    bus.mem_wdata       = wd;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mem_resp) got = 1'b1;
    end
    idle_inputs();
    check({nm, "_latency"}, got ? 64'(n) : 64'hFFFF, 64'(exp_n));
    check({nm, "_rd_cycles"}, 64'(rd_cyc), 64'(exp_rc));
    check({nm, "_wr_cycles"}, 64'(wr_cyc), 64'(exp_wc));
    if (exp_rc + exp_wc > 0) check({nm, "_pmem_address"}, 64'(last_addr), 64'(exp_addr));
  endtask

  initial begin
    int rc0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_outputs");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // name rd wr mask addr wdata lat word exp_rdata exp_err has_wr exp_w n rc wc addr
    req("read_lat3",   1, 0, 2'b00, 16'h0041, 16'h0000, 3, 16'hBEEF, 16'hBEEF, 0, 0, 16'h0000, 5, 3, 0, 16'h0040);
    req("write_full",  0, 1, 2'b11, 16'h0100, 16'h1234, 2, 16'h0000, 16'h0000, 0, 1, 16'h1234, 4, 0, 2, 16'h0100);
    req("rmw_low",     0, 1, 2'b01, 16'h0203, 16'hAA55, 1, 16'hC3C3, 16'h0000, 0, 1, 16'hC355, 4, 1, 1, 16'h0202);
    req("rmw_high",    0, 1, 2'b10, 16'h0202, 16'hAA55, 1, 16'hC3C3, 16'h0000, 0, 1, 16'hAAC3, 4, 1, 1, 16'h0202);
    req("write_mask0", 0, 1, 2'b00, 16'h0300, 16'hFFFF, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 2, 0, 0, 16'h0000);
    req("read_and_wr", 1, 1, 2'b11, 16'hFFFF, 16'h7777, 1, 16'h5A5A, 16'h5A5A, 0, 0, 16'h0000, 3, 1, 0, 16'hFFFE);
    req("read_tmo",    1, 0, 2'b00, 16'h0500, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 10, 8, 0, 16'h0500);

    rc0 = resp_cnt;
    inject_late = 1'b1;
    repeat (4) @(negedge clk);
    check("late_resp_ignored", 64'(resp_cnt), 64'(rc0));
    check("late_resp_no_strobe", {bus.pmem_read, bus.pmem_write}, 64'd0);

    req("read_expiry", 1, 0, 2'b00, 16'h0600, 16'h0000, 8, 16'h1357, 16'h1357, 0, 0, 16'h0000, 10, 8, 0, 16'h0600);
    req("rmw_tmo",     0, 1, 2'b01, 16'h0700, 16'h00FF, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 10, 8, 0, 16'h0700);

    // Reset while in RMW_READ: no write and no CPU response may follow.
    resp_lat = 0;
    rd_cyc   = 0;
    wr_cyc   = 0;
    rc0      = resp_cnt;
    @(posedge clk);
    #1;
    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = 2'b10;
    bus.mem_address     = 16'h0800;
    bus.mem_wdata       = 16'h1111;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("midop_reset_outputs");
    repeat (4) @(negedge clk);
    check("midop_reset_rd_cycles", 64'(rd_cyc), 64'd3);
    check("midop_reset_no_write", 64'(wr_cyc), 64'd0);
    check("midop_reset_no_resp", 64'(resp_cnt), 64'(rc0));

    req("read_after_rst", 1, 0, 2'b00, 16'h0901, 16'h0000, 2, 16'h2468, 16'h2468, 0, 0, 16'h0000, 4, 2, 0, 16'h0900);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("wq_drained", 64'(wq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
